// File: rtl/chess_pkg.sv
// Shared types and helpers for the chessboard move sequencer.
// square_t indexes squares as row*8+col; row 0 is the black back rank.
package chess_pkg;

   typedef logic [5:0] square_t;

   typedef enum logic [1:0] {IDLE, LIFT1, LIFT2, ERROR} seq_state_t;

   localparam logic [63:0] INIT_BOARD_C = 64'hFFFF_0000_0000_FFFF;

   function automatic square_t onehot_idx(input logic [63:0] v);
      square_t idx;
      idx = '0;
      for (int unsigned i = 0; i < 64; i++)
         if (v[i]) idx = square_t'(i);
      return idx;
   endfunction

   function automatic logic single_bit(input logic [63:0] v);
      return (v != '0) && ((v & (v - 64'd1)) == '0);
   endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// Debounces the raw 64-bit occupancy vector into a settled board.
// commit is combinational so the caller can decode events against the pre-commit board.
module sensor_debouncer
   import chess_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 4,
   parameter logic [63:0] INIT_BOARD   = INIT_BOARD_C
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] sensor_state,
   output logic [63:0] sample,
   output logic [63:0] stable_board,
   output logic        board_upd,
   output logic        commit
);

   localparam int unsigned CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

   logic [CW-1:0] cnt;

   // cnt saturates, so a settled sample commits exactly once
   assign commit = (cnt == CNT_MAX) && (sample != stable_board);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample       <= INIT_BOARD;
         stable_board <= INIT_BOARD;
         cnt          <= '0;
         board_upd    <= 1'b0;
      end else begin
         board_upd <= commit;
         if (commit)
            stable_board <= sample;
         if (sensor_state != sample) begin
            sample <= sensor_state;
            cnt    <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/move_sequencer.sv
// Debounced board tracker reporting completed moves (from/to/capture) with a sticky error.
// Define MOVE_TIMEOUT_EN to bound the time spent with pieces lifted.
module move_sequencer
   import chess_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 4,
   parameter logic [63:0] INIT_BOARD   = INIT_BOARD_C
`ifdef MOVE_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC  = 1024
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] sensor_state,
   input  logic        clear_err,
   output logic [63:0] stable_board,
   output logic        board_upd,
   output logic        move_valid,
   output logic [5:0]  move_from,
   output logic [5:0]  move_to,
   output logic        move_cap,
   output logic        busy,
   output logic        err
);

   logic [63:0] sample;
   logic        commit;

   sensor_debouncer #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .INIT_BOARD   (INIT_BOARD)
   ) u_deb (
      .clk          (clk),
      .rst          (rst),
      .sensor_state (sensor_state),
      .sample       (sample),
      .stable_board (stable_board),
      .board_upd    (board_upd),
      .commit       (commit)
   );

   logic [63:0] lift, place, chg;
   logic        single, is_place;
   square_t     sq;

   assign lift     = stable_board & ~sample;
   assign place    = ~stable_board & sample;
   assign chg      = lift | place;
   assign single   = single_bit(chg);
   assign sq       = onehot_idx(chg);
   assign is_place = |place;

   seq_state_t state, state_n;
   square_t    from_r, from_n, vict_r, vict_n;
   square_t    mv_from_n, mv_to_n;
   logic       mv_cap_n, mv_valid_n;

`ifdef MOVE_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] timer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         timer <= '0;
      else if (state_n != state)
         timer <= '0;
      else if (state == LIFT1 || state == LIFT2)
         timer <= timer + 1'b1;
   end
`endif

   always_comb begin
      state_n    = state;
      from_n     = from_r;
      vict_n     = vict_r;
      mv_valid_n = 1'b0;
      mv_from_n  = move_from;
      mv_to_n    = move_to;
      mv_cap_n   = move_cap;
      case (state)
         IDLE: if (commit) begin
            if (!single || is_place) begin
               state_n = ERROR;
            end else begin
               state_n = LIFT1;
               from_n  = sq;
            end
         end
         LIFT1: if (commit) begin
            if (!single) begin
               state_n = ERROR;
            end else if (is_place) begin
               state_n = IDLE;
               if (sq != from_r) begin
                  mv_valid_n = 1'b1;
                  mv_from_n  = from_r;
                  mv_to_n    = sq;
                  mv_cap_n   = 1'b0;
               end
            end else begin
               state_n = LIFT2;
               vict_n  = sq;
            end
         end
         LIFT2: if (commit) begin
            state_n = ERROR;
            if (single && is_place && sq == vict_r) begin
               state_n    = IDLE;
               mv_valid_n = 1'b1;
               mv_from_n  = from_r;
               mv_to_n    = vict_r;
               mv_cap_n   = 1'b1;
            end else if (single && is_place && sq == from_r) begin
               state_n    = IDLE;
               mv_valid_n = 1'b1;
               mv_from_n  = vict_r;
               mv_to_n    = from_r;
               mv_cap_n   = 1'b1;
            end
         end
         ERROR: if (clear_err) state_n = IDLE;
         default: state_n = ERROR;
      endcase
`ifdef MOVE_TIMEOUT_EN
      if ((state == LIFT1 || state == LIFT2) && state_n == state &&
          timer == TW'(TIMEOUT_CYC - 1))
         state_n = ERROR;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         from_r     <= '0;
         vict_r     <= '0;
         move_valid <= 1'b0;
         move_from  <= '0;
         move_to    <= '0;
         move_cap   <= 1'b0;
      end else begin
         state      <= state_n;
         from_r     <= from_n;
         vict_r     <= vict_n;
         move_valid <= mv_valid_n;
         move_from  <= mv_from_n;
         move_to    <= mv_to_n;
         move_cap   <= mv_cap_n;
      end
   end

   assign busy = (state != IDLE);
   assign err  = (state == ERROR);

endmodule
